// File: rtl/fix_parser_pkg.sv
// Shared FIX tag=value parsing constants, field-scanner states and a digit classifier.
package fix_parser_pkg;

    localparam logic [7:0] SOH_CHAR = 8'h01;
    localparam logic [7:0] SEP_CHAR = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    typedef enum logic [1:0] {
        TAG,
        VAL,
        SKIP
    } fix_fld_state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_beat_serializer.sv
// Walks a multi-byte input beat one byte per cycle, MSB lane first, and acknowledges the beat
// on the cycle its last kept lane is consumed.
module fix_beat_serializer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_take
);

    localparam int CUR_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CUR_W-1:0] CUR_FIRST = CUR_W'(DATA_BYTES - 1);

    logic [CUR_W-1:0] cursor;
    logic             last_lane;

    // keep is contiguous from the MSB lane, so the beat ends at the first cleared lane below the cursor
    always_comb begin
        byte_data  = in_data[{cursor, 3'b000} +: 8];
        byte_valid = in_valid && !rst;
        last_lane  = (cursor == '0) || !in_keep[cursor - CUR_W'(1)];
        in_ready   = byte_take && last_lane;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor <= CUR_FIRST;
        end else if (byte_take) begin
            cursor <= last_lane ? CUR_FIRST : cursor - CUR_W'(1);
        end
    end

    keep_nonzero_a: assert property (@(posedge clk) disable iff (rst) in_valid |-> (in_keep != '0));

endmodule

// File: rtl/fix_field_extractor.sv
// Sequential FIX field extractor: decodes tag digits, collects value bytes and emits one
// <tag, value, length, trunc> record per SOH-terminated field through a valid/ready register.
module fix_field_extractor
    import fix_parser_pkg::*;
#(
    parameter int DATA_BYTES    = 4,
    parameter int TAG_W         = 16,
    parameter int MAX_VAL_BYTES = 32,
    parameter int CNT_W         = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [8*DATA_BYTES-1:0]              in_data,
    input  logic [DATA_BYTES-1:0]                in_keep,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TAG_W-1:0]                     out_tag,
    output logic [8*MAX_VAL_BYTES-1:0]           out_val,
    output logic [$clog2(MAX_VAL_BYTES+1)-1:0]   out_len,
    output logic                                 out_trunc,
    output logic [CNT_W-1:0]                     field_cnt,
    output logic [CNT_W-1:0]                     err_cnt
);

    localparam int LEN_W   = $clog2(MAX_VAL_BYTES + 1);
    localparam int VAL_W   = 8 * MAX_VAL_BYTES;
    localparam int DIG_MAX = TAG_W / 3 + 1;
    localparam int DIG_W   = $clog2(DIG_MAX + 2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    fix_fld_state_e   state, state_nx;
    logic [TAG_W-1:0] tag_acc;
    logic [DIG_W-1:0] dig_cnt;
    logic [VAL_W-1:0] val_acc;
    logic [LEN_W-1:0] len_acc;
    logic             trunc_acc;

    logic [7:0]       cur_byte;
    logic             byte_valid, byte_take, stall;
    logic [TAG_W+3:0] tag_mac;
    logic             tag_ovf;
    logic             load, err, acc_clear, dig_step, val_start, val_store, trunc_set;

    fix_beat_serializer #(
        .DATA_BYTES(DATA_BYTES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .byte_data (cur_byte),
        .byte_valid(byte_valid),
        .byte_take (byte_take)
    );

    // A field-closing SOH waits while the previous record is still unclaimed
    always_comb begin
        stall     = byte_valid && (state == VAL) && (cur_byte == SOH_CHAR) && out_valid && !out_ready;
        byte_take = byte_valid && !stall;
        tag_mac   = {4'b0000, tag_acc} * (TAG_W+4)'(10) + (TAG_W+4)'(cur_byte - ASCII_0);
        tag_ovf   = (tag_mac[TAG_W+3:TAG_W] != 4'b0000) || (dig_cnt >= DIG_W'(DIG_MAX));
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        err       = 1'b0;
        acc_clear = 1'b0;
        dig_step  = 1'b0;
        val_start = 1'b0;
        val_store = 1'b0;
        trunc_set = 1'b0;
        if (byte_take) begin
            unique case (state)
                TAG: begin
                    if (is_digit(cur_byte)) begin
                        if (tag_ovf) state_nx = SKIP;
                        else         dig_step = 1'b1;
                    end else if (cur_byte == SEP_CHAR) begin
                        if (dig_cnt != '0) begin
                            state_nx  = VAL;
                            val_start = 1'b1;
                        end else begin
                            state_nx = SKIP;
                        end
                    end else if (cur_byte == SOH_CHAR) begin
                        // a bare SOH is an empty field; digits with no '=' are malformed
                        if (dig_cnt != '0) begin
                            err       = 1'b1;
                            acc_clear = 1'b1;
                        end
                    end else begin
                        state_nx = SKIP;
                    end
                end
                VAL: begin
                    if (cur_byte == SOH_CHAR) begin
                        load      = 1'b1;
                        acc_clear = 1'b1;
                        state_nx  = TAG;
                    end else if (len_acc < LEN_W'(MAX_VAL_BYTES)) begin
                        val_store = 1'b1;
                    end else begin
                        trunc_set = 1'b1;
                    end
                end
                SKIP: begin
                    if (cur_byte == SOH_CHAR) begin
                        err       = 1'b1;
                        acc_clear = 1'b1;
                        state_nx  = TAG;
                    end
                end
                default: state_nx = TAG;
            endcase
        end
    end

    // Scan stage: field state and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TAG;
            tag_acc   <= '0;
            dig_cnt   <= '0;
            val_acc   <= '0;
            len_acc   <= '0;
            trunc_acc <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc_clear) begin
                tag_acc   <= '0;
                dig_cnt   <= '0;
                val_acc   <= '0;
                len_acc   <= '0;
                trunc_acc <= 1'b0;
            end else begin
                if (dig_step) begin
                    tag_acc <= tag_mac[TAG_W-1:0];
                    dig_cnt <= dig_cnt + DIG_W'(1);
                end
                if (val_start) begin
                    val_acc   <= '0;
                    len_acc   <= '0;
                    trunc_acc <= 1'b0;
                end
                if (val_store) begin
                    val_acc[{len_acc, 3'b000} +: 8] <= cur_byte;
                    len_acc                         <= len_acc + LEN_W'(1);
                end
                if (trunc_set) trunc_acc <= 1'b1;
            end
        end
    end

    // Output stage: one-entry record register and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_val   <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
            field_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_tag   <= tag_acc;
                out_val   <= val_acc;
                out_len   <= len_acc;
                out_trunc <= trunc_acc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load) field_cnt <= sat_inc(field_cnt);
            if (err)  err_cnt   <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_fix_field_extractor.sv
// Directed bench for fix_field_extractor: table of byte streams with expected records, plus
// hand-written backpressure and mid-field reset sequences.
module tb_fix_field_extractor;

    localparam int DB    = 4;
    localparam int TW    = 8;
    localparam int MVB   = 4;
    localparam int CW    = 3;
    localparam int LW    = $clog2(MVB + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [8*DB-1:0]   in_data;
    logic [DB-1:0]     in_keep;
    logic              out_valid;
    logic              out_ready;
    logic [TW-1:0]     out_tag;
    logic [8*MVB-1:0]  out_val;
    logic [LW-1:0]     out_len;
    logic              out_trunc;
    logic [CW-1:0]     field_cnt;
    logic [CW-1:0]     err_cnt;

    fix_field_extractor #(
        .DATA_BYTES(DB), .TAG_W(TW), .MAX_VAL_BYTES(MVB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_val(out_val), .out_len(out_len), .out_trunc(out_trunc),
        .field_cnt(field_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]    tag;
        logic [8*MVB-1:0] val;
        logic [LW-1:0]    len;
        logic             trunc;
    } rec_t;

    typedef struct {
        string stream;
        int    nrec;
        rec_t  r0;
        rec_t  r1;
        int    errs;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t recq[$];
    rec_t mon_r;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_r.tag   = out_tag;
            mon_r.val   = out_val;
            mon_r.len   = out_len;
            mon_r.trunc = out_trunc;
            recq.push_back(mon_r);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // '|' in a stream string stands for SOH; beats are packed MSB lane first
    task automatic drive(input string s);
        int          n;
        int          nb;
        int          t;
        logic [31:0] d;
        logic [3:0]  k;
        n  = s.len();
        nb = (n + DB - 1) / DB;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < DB; l++) begin
                if (b * DB + l < n) begin
                    d[8*(DB-1-l) +: 8] = (s[b*DB+l] == "|") ? 8'h01 : 8'(s[b*DB+l]);
                    k[DB-1-l]          = 1'b1;
                end
            end
            in_data  = d;
            in_keep  = k;
            in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 300);
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_timeout: stream %s beat %0d got no in_ready", s, b);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        in_keep  = '0;
    endtask

    task automatic check_rec(input string name, input rec_t got, input rec_t exp);
        check({name, ".tag"},   64'(got.tag),   64'(exp.tag));
        check({name, ".val"},   64'(got.val),   64'(exp.val));
        check({name, ".len"},   64'(got.len),   64'(exp.len));
        check({name, ".trunc"}, 64'(got.trunc), 64'(exp.trunc));
    endtask

    function automatic int sat_cnt(input int c);
        return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
    endfunction

    vec_t vt[9];
    int   exp_fld;
    int   exp_err;
    rec_t got;
    rec_t exp_r;

    initial begin
        vt[0] = '{"35=D|49=AB|",       2, '{8'd35, 32'h00000044, 3'd1, 1'b0}, '{8'd49, 32'h00004241, 3'd2, 1'b0}, 0};
        vt[1] = '{"58=HELLOWORLD|",    1, '{8'd58, 32'h4C4C4548, 3'd4, 1'b1}, '0, 0};
        vt[2] = '{"3A=X|8=Y|",         1, '{8'd8,  32'h00000059, 3'd1, 1'b0}, '0, 1};
        vt[3] = '{"=5|",               0, '0, '0, 1};
        vt[4] = '{"||",                0, '0, '0, 0};
        vt[5] = '{"300=|",             0, '0, '0, 1};
        vt[6] = '{"35=|",              1, '{8'd35, 32'h00000000, 3'd0, 1'b0}, '0, 0};
        vt[7] = '{"7=a=b|",            1, '{8'd7,  32'h00623D61, 3'd3, 1'b0}, '0, 0};
        vt[8] = '{"12|",               0, '0, '0, 1};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h33353D44;
        in_keep   = 4'b1111;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_tag",   64'(out_tag),   64'd0);
        check("rst.field_cnt", 64'(field_cnt), 64'd0);
        check("rst.err_cnt",   64'(err_cnt),   64'd0);
        in_valid = 1'b0;
        in_data  = '0;
        in_keep  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        exp_fld = 0;
        exp_err = 0;
        for (int i = 0; i < 9; i++) begin
            recq.delete();
            drive(vt[i].stream);
            repeat (6) @(posedge clk);
            #1;
            exp_fld = sat_cnt(exp_fld + vt[i].nrec);
            exp_err = sat_cnt(exp_err + vt[i].errs);
            check($sformatf("v%0d.nrec", i), 64'(recq.size()), 64'(vt[i].nrec));
            for (int r = 0; r < vt[i].nrec; r++) begin
                got   = (r < recq.size()) ? recq[r] : '0;
                exp_r = (r == 0) ? vt[i].r0 : vt[i].r1;
                check_rec($sformatf("v%0d.r%0d", i, r), got, exp_r);
            end
            check($sformatf("v%0d.field_cnt", i), 64'(field_cnt), 64'(exp_fld));
            check($sformatf("v%0d.err_cnt", i),   64'(err_cnt),   64'(exp_err));
        end

        // backpressure: second SOH must wait until record 1 is taken
        recq.delete();
        out_ready = 1'b0;
        fork
            drive("1=a|2=b|");
            begin
                repeat (15) @(negedge clk);
                check("bp.out_valid", 64'(out_valid), 64'd1);
                check("bp.out_tag",   64'(out_tag),   64'd1);
                check("bp.out_val",   64'(out_val),   64'h61);
                check("bp.in_ready",  64'(in_ready),  64'd0);
                check("bp.held",      64'(recq.size()), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        exp_fld = sat_cnt(exp_fld + 2);
        check("bp.nrec", 64'(recq.size()), 64'd2);
        got = (recq.size() > 0) ? recq[0] : '0;
        check_rec("bp.r0", got, '{8'd1, 32'h61, 3'd1, 1'b0});
        got = (recq.size() > 1) ? recq[1] : '0;
        check_rec("bp.r1", got, '{8'd2, 32'h62, 3'd1, 1'b0});
        check("bp.field_cnt_sat", 64'(field_cnt), 64'(exp_fld));
        check("bp.out_valid_clr", 64'(out_valid), 64'd0);

        // reset mid-value with a record still pending
        recq.delete();
        out_ready = 1'b0;
        drive("9=q|");
        drive("55=x");
        in_data  = {8'h79, 8'h7A, 16'h0000};
        in_keep  = 4'b1100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mr.pending", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mr.out_valid", 64'(out_valid), 64'd0);
        check("mr.field_cnt", 64'(field_cnt), 64'd0);
        check("mr.err_cnt",   64'(err_cnt),   64'd0);
        check("mr.in_ready",  64'(in_ready),  64'd0);
        in_valid = 1'b0;
        in_data  = '0;
        in_keep  = '0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drive("1=z|");
        repeat (6) @(posedge clk);
        #1;
        check("mr.nrec", 64'(recq.size()), 64'd1);
        got = (recq.size() > 0) ? recq[0] : '0;
        check_rec("mr.r0", got, '{8'd1, 32'h7A, 3'd1, 1'b0});
        check("mr.field_cnt_after", 64'(field_cnt), 64'd1);
        check("mr.err_cnt_after",   64'(err_cnt),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
